// File: rtl/stream_mux_if.sv
// Stream mux handshake bundle: N_CH input lanes in, one tagged output stream out.
interface stream_mux_if #(
    parameter int D_WIDTH = 8,
    parameter int N_CH    = 4,
    parameter int SEL_W   = 2
);
    logic [N_CH*D_WIDTH-1:0] data_i;
    logic [N_CH-1:0]         valid_i;
    logic [N_CH-1:0]         ready_o;
    logic [D_WIDTH-1:0]      data_o;
    logic [SEL_W-1:0]        ch_o;
    logic                    valid_o;
    logic                    ready_i;

    // Producer/consumer side of the mux.
    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, ch_o, valid_o
    );

    // The mux itself.
    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, ch_o, valid_o
    );
endinterface

// File: rtl/stream_mux.sv
// N-channel stream multiplexer with fixed-select or round-robin grant,
// a 2-entry {data, channel} output FIFO and a saturating accepted-beat counter.
module stream_mux #(
    parameter int D_WIDTH = 8,
    parameter int N_CH    = 4,
    parameter int SEL_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_i,
    input  logic [SEL_W-1:0] select,
    stream_mux_if.slave      bus,
    output logic [15:0]      beat_cnt_o
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t               occ_q;
    occ_t               occ_d;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   grant;
    logic               grant_vld;
    logic [N_CH-1:0]    rot;
    logic [31:0]        sum;
    logic [N_CH-1:0]    ready;
    logic               accept;
    logic               pop;
    logic [D_WIDTH-1:0] in_data;
    logic [D_WIDTH-1:0] tail_data;
    logic [SEL_W-1:0]   tail_ch;
    logic               load_head_in;
    logic               load_head_tail;
    logic               load_tail_in;

    // Grant selection: fixed index, or first valid lane at/after rr_ptr (rotated search).
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rot       = '0;
        sum       = '0;
        if (!mode_i) begin
            if (32'(select) < 32'(N_CH)) begin
                grant     = select;
                grant_vld = 1'b1;
            end
        end else begin
            rot = N_CH'({bus.valid_i, bus.valid_i} >> rr_ptr);
            for (int unsigned j = 0; j < N_CH; j++) begin
                if (!grant_vld && rot[j]) begin
                    sum = 32'(rr_ptr) + j;
                    if (sum >= 32'(N_CH)) begin
                        sum = sum - 32'(N_CH);
                    end
                    grant     = SEL_W'(sum);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Ready only on the granted lane while the FIFO has room and reset is released.
    always_comb begin
        ready   = '0;
        in_data = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (32'(grant) == k) begin
                in_data = bus.data_i[k*D_WIDTH +: D_WIDTH];
                if (grant_vld && rst_n && (occ_q != OCC_FULL)) begin
                    ready[k] = 1'b1;
                end
            end
        end
    end

    assign bus.ready_o = ready;
    assign accept      = |(ready & bus.valid_i);
    assign pop         = (occ_q != OCC_EMPTY) && bus.ready_i;
    assign bus.valid_o = (occ_q != OCC_EMPTY);

    // FIFO occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Occupancy transitions and which FIFO slot gets written.
    // The head slot is the output register itself; the tail only fills when a
    // push arrives while one beat is already waiting and nothing pops.
    always_comb begin
        occ_d          = occ_q;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail_in   = 1'b0;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    occ_d        = OCC_ONE;
                    load_head_in = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    occ_d        = OCC_FULL;
                    load_tail_in = 1'b1;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    occ_d          = OCC_ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // FIFO storage: head drives data_o/ch_o directly and holds when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_o <= '0;
            bus.ch_o   <= '0;
            tail_data  <= '0;
            tail_ch    <= '0;
        end else begin
            if (load_head_in) begin
                bus.data_o <= in_data;
                bus.ch_o   <= grant;
            end else if (load_head_tail) begin
                bus.data_o <= tail_data;
                bus.ch_o   <= tail_ch;
            end
            if (load_tail_in) begin
                tail_data <= in_data;
                tail_ch   <= grant;
            end
        end
    end

    // Round-robin pointer advances past the lane just served; fixed mode leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && mode_i) begin
            if (32'(grant) == 32'(N_CH - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant + 1'b1;
            end
        end
    end

    // Saturating count of accepted input beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_o <= '0;
        end else if (accept && (beat_cnt_o != 16'hFFFF)) begin
            beat_cnt_o <= beat_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux (4 lanes, 8-bit data, 3-bit select).
`timescale 1ns/1ps
module tb_stream_mux;
    localparam int DW = 8;
    localparam int NC = 4;
    localparam int SW = 3;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          mode_i = 1'b0;
    logic [SW-1:0] select = '0;
    logic [15:0]   beat_cnt_o;
    int            n_cmp  = 0;
    int            n_err  = 0;

    stream_mux_if #(.D_WIDTH(DW), .N_CH(NC), .SEL_W(SW)) bus ();

    stream_mux #(.D_WIDTH(DW), .N_CH(NC), .SEL_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_i     (mode_i),
        .select     (select),
        .bus        (bus),
        .beat_cnt_o (beat_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.valid_i = '0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        mode_i      = 1'b0;
        select      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        #1;
        rst_n       = 1'b0;
        bus.valid_i = 4'b1111;
        bus.data_i  = 32'hDEAD_BEEF;
        bus.ready_i = 1'b1;
        #2;
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.ready_o); end
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.data_o); end
        n_cmp++; if (bus.ch_o !== 3'd0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", bus.ch_o); end
        n_cmp++; if (beat_cnt_o !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: got %h want 0000", beat_cnt_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", bus.valid_o); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        apply_reset();
        mode_i      = 1'b0;
        select      = 3'd2;
        bus.data_i  = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.valid_i = 4'b0100;
        bus.ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b0100) begin n_err++; $display("FAIL fixed_ready: got %b want 0100", bus.ready_o); end
        tick();
        bus.valid_i = 4'b0000;
        n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL fixed_valid: got %b want 1", bus.valid_o); end
        n_cmp++; if (bus.data_o !== 8'hA5) begin n_err++; $display("FAIL fixed_data: got %h want a5", bus.data_o); end
        n_cmp++; if (bus.ch_o !== 3'd2) begin n_err++; $display("FAIL fixed_ch: got %0d want 2", bus.ch_o); end
        n_cmp++; if (beat_cnt_o !== 16'd1) begin n_err++; $display("FAIL fixed_cnt: got %0d want 1", beat_cnt_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL fixed_drain: got %b want 0", bus.valid_o); end
        n_cmp++; if (bus.data_o !== 8'hA5) begin n_err++; $display("FAIL fixed_hold_data: got %h want a5", bus.data_o); end
        idle();
    endtask

    task automatic test_round_robin();
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        mode_i      = 1'b1;
        bus.data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.valid_i = 4'b1111;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b want 1", i, bus.valid_o); end
            n_cmp++; if (bus.ch_o !== SW'(exp_ch[i])) begin n_err++; $display("FAIL rr_ch[%0d]: got %0d want %0d", i, bus.ch_o, exp_ch[i]); end
            n_cmp++; if (bus.data_o !== DW'(8'h10 + exp_ch[i])) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", i, bus.data_o, 8'h10 + exp_ch[i]); end
        end
        n_cmp++; if (beat_cnt_o !== 16'd5) begin n_err++; $display("FAIL rr_cnt: got %0d want 5", beat_cnt_o); end
        idle();
    endtask

    task automatic test_rr_skip();
        apply_reset();
        mode_i      = 1'b1;
        bus.data_i  = {8'h43, 8'h42, 8'h41, 8'h40};
        bus.valid_i = 4'b1010;
        bus.ready_i = 1'b1;
        tick();
        n_cmp++; if (bus.ch_o !== 3'd1) begin n_err++; $display("FAIL skip_ch1: got %0d want 1", bus.ch_o); end
        n_cmp++; if (bus.data_o !== 8'h41) begin n_err++; $display("FAIL skip_data1: got %h want 41", bus.data_o); end
        tick();
        n_cmp++; if (bus.ch_o !== 3'd3) begin n_err++; $display("FAIL skip_ch3: got %0d want 3", bus.ch_o); end
        mode_i      = 1'b0;
        select      = 3'd2;
        bus.valid_i = 4'b0100;
        tick();
        n_cmp++; if (bus.ch_o !== 3'd2) begin n_err++; $display("FAIL skip_fixed_ch: got %0d want 2", bus.ch_o); end
        mode_i      = 1'b1;
        bus.valid_i = 4'b1111;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b0001) begin n_err++; $display("FAIL skip_ptr_ready: got %b want 0001", bus.ready_o); end
        tick();
        n_cmp++; if (bus.ch_o !== 3'd0) begin n_err++; $display("FAIL skip_ptr_ch: got %0d want 0", bus.ch_o); end
        n_cmp++; if (bus.data_o !== 8'h40) begin n_err++; $display("FAIL skip_ptr_data: got %h want 40", bus.data_o); end
        idle();
    endtask

    task automatic test_backpressure();
        apply_reset();
        mode_i      = 1'b0;
        select      = 3'd1;
        bus.ready_i = 1'b0;
        bus.data_i  = 32'h0000_1100;
        bus.valid_i = 4'b0010;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b0010) begin n_err++; $display("FAIL bp_ready0: got %b want 0010", bus.ready_o); end
        tick();
        bus.data_i = 32'h0000_2200;
        n_cmp++; if (bus.ready_o !== 4'b0010) begin n_err++; $display("FAIL bp_ready1: got %b want 0010", bus.ready_o); end
        n_cmp++; if (bus.data_o !== 8'h11) begin n_err++; $display("FAIL bp_head1: got %h want 11", bus.data_o); end
        tick();
        bus.data_i = 32'h0000_3300;
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL bp_full_ready: got %b want 0000", bus.ready_o); end
        n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_full_valid: got %b want 1", bus.valid_o); end
        tick();
        n_cmp++; if (bus.data_o !== 8'h11) begin n_err++; $display("FAIL bp_stall_data: got %h want 11", bus.data_o); end
        n_cmp++; if (beat_cnt_o !== 16'd2) begin n_err++; $display("FAIL bp_stall_cnt: got %0d want 2", beat_cnt_o); end
        bus.ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL bp_full_rdyi: got %b want 0000", bus.ready_o); end
        tick();
        bus.valid_i = 4'b0000;
        n_cmp++; if (bus.data_o !== 8'h22) begin n_err++; $display("FAIL bp_second: got %h want 22", bus.data_o); end
        n_cmp++; if (bus.ch_o !== 3'd1) begin n_err++; $display("FAIL bp_second_ch: got %0d want 1", bus.ch_o); end
        n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_second_valid: got %b want 1", bus.valid_o); end
        tick();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", bus.valid_o); end
        n_cmp++; if (beat_cnt_o !== 16'd2) begin n_err++; $display("FAIL bp_cnt: got %0d want 2", beat_cnt_o); end
        idle();
    endtask

    task automatic test_bad_select();
        apply_reset();
        mode_i      = 1'b0;
        select      = 3'd7;
        bus.data_i  = 32'h7766_5544;
        bus.valid_i = 4'b1111;
        bus.ready_i = 1'b1;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL badsel_ready: got %b want 0000", bus.ready_o); end
        repeat (3) tick();
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL badsel_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (beat_cnt_o !== 16'd0) begin n_err++; $display("FAIL badsel_cnt: got %0d want 0", beat_cnt_o); end
        select = 3'd3;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b1000) begin n_err++; $display("FAIL badsel_switch: got %b want 1000", bus.ready_o); end
        idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        mode_i      = 1'b1;
        bus.data_i  = {8'h63, 8'h62, 8'h61, 8'h60};
        bus.valid_i = 4'b0011;
        bus.ready_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL ar_full_ready: got %b want 0000", bus.ready_o); end
        n_cmp++; if (beat_cnt_o !== 16'd2) begin n_err++; $display("FAIL ar_pre_cnt: got %0d want 2", beat_cnt_o); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", bus.valid_o); end
        n_cmp++; if (beat_cnt_o !== 16'd0) begin n_err++; $display("FAIL ar_cnt: got %0d want 0", beat_cnt_o); end
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL ar_ready: got %b want 0000", bus.ready_o); end
        n_cmp++; if (bus.data_o !== 8'h00) begin n_err++; $display("FAIL ar_data: got %h want 00", bus.data_o); end
        tick();
        rst_n       = 1'b1;
        bus.data_i  = {8'h73, 8'h72, 8'h71, 8'h70};
        bus.valid_i = 4'b1111;
        #1;
        n_cmp++; if (bus.ready_o !== 4'b0001) begin n_err++; $display("FAIL ar_rel_ready: got %b want 0001", bus.ready_o); end
        tick();
        n_cmp++; if (bus.ch_o !== 3'd0) begin n_err++; $display("FAIL ar_first_ch: got %0d want 0", bus.ch_o); end
        n_cmp++; if (bus.data_o !== 8'h70) begin n_err++; $display("FAIL ar_first_data: got %h want 70", bus.data_o); end
        n_cmp++; if (bus.ready_o !== 4'b0010) begin n_err++; $display("FAIL ar_room: got %b want 0010", bus.ready_o); end
        tick();
        n_cmp++; if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL ar_refull: got %b want 0000", bus.ready_o); end
        n_cmp++; if (beat_cnt_o !== 16'd2) begin n_err++; $display("FAIL ar_post_cnt: got %0d want 2", beat_cnt_o); end
        idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        mode_i      = 1'b1;
        bus.data_i  = 32'h0403_0201;
        bus.valid_i = 4'b1111;
        bus.ready_i = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        n_cmp++; if (beat_cnt_o !== 16'hFFFE) begin n_err++; $display("FAIL sat_pre: got %h want fffe", beat_cnt_o); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (beat_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_top: got %h want ffff", beat_cnt_o); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (beat_cnt_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", beat_cnt_o); end
        n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL sat_stream: got %b want 1", bus.valid_o); end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_rr_skip();
        test_backpressure();
        test_bad_select();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
